spc7110_psram_arbiter: RTL and testbench

Arbitrates the single SPC7110 PSRAM bus between four requesters: SNES program-ROM fetches, Data ROM MMIO direct reads, the microcontroller, and the decompression unit (DCU). Requests are granted by fixed priority with a DCU anti-starvation override. Every granted access runs to completion without preemption. Each access has a fixed PSRAM timing window, and results return to the requester as a one-cycle valid or ack pulse.

---
 rtl/spc7110_pkg.sv | 20 ++
 rtl/spc7110_psram_arbiter_if.sv | 51 +++++
 rtl/spc7110_arb_prio.sv | 47 ++++
 rtl/spc7110_psram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spc7110_psram_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spc7110_pkg.sv
// Shared types and constants for the SPC7110 PSRAM arbiter slice.
// Holds the sequencer states, the requester IDs and the default access window.
package spc7110_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_SNES   = 2'd0,
    REQ_DIRECT = 2'd1,
    REQ_MCU    = 2'd2,
    REQ_DCU    = 2'd3
  } req_id_t;

  localparam int unsigned DEFAULT_ACCESS_CYCLES = 5;

endpackage

// File: rtl/spc7110_psram_arbiter_if.sv
// Requester and PSRAM bus bundle for the SPC7110 PSRAM arbiter.
// slave = arbiter side, master = requesters plus the PSRAM read-data source.
interface spc7110_psram_arbiter_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              snes_req;
  logic [ADDR_W-1:0] snes_addr;
  logic [15:0]       snes_data;
  logic              snes_valid;

  logic              direct_req;
  logic [ADDR_W-1:0] direct_addr;
  logic [15:0]       direct_data;
  logic              direct_valid;

  logic              mcu_req;
  logic              mcu_we;
  logic [ADDR_W-1:0] mcu_addr;
  logic [15:0]       mcu_wdata;
  logic [15:0]       mcu_rdata;
  logic              mcu_ack;

  logic              dcu_req;
  logic [ADDR_W-1:0] dcu_addr;
  logic [15:0]       dcu_rdata;
  logic              dcu_ack;

  logic [ADDR_W-1:0] psram_addr;
  logic [15:0]       psram_din;
  logic [15:0]       psram_dout;
  logic              psram_oe_n;
  logic              psram_we_n;

  modport slave (
    input  snes_req, snes_addr, direct_req, direct_addr,
           mcu_req, mcu_we, mcu_addr, mcu_wdata,
           dcu_req, dcu_addr, psram_din,
    output snes_data, snes_valid, direct_data, direct_valid,
           mcu_rdata, mcu_ack, dcu_rdata, dcu_ack,
           psram_addr, psram_dout, psram_oe_n, psram_we_n
  );

  modport master (
    output snes_req, snes_addr, direct_req, direct_addr,
           mcu_req, mcu_we, mcu_addr, mcu_wdata,
           dcu_req, dcu_addr, psram_din,
    input  snes_data, snes_valid, direct_data, direct_valid,
           mcu_rdata, mcu_ack, dcu_rdata, dcu_ack,
           psram_addr, psram_dout, psram_oe_n, psram_we_n
  );
endinterface

// File: rtl/spc7110_arb_prio.sv
// Fixed-priority winner select (snes > direct > mcu > dcu) with a DCU
// anti-starvation override driven by a saturating grant counter.
module spc7110_arb_prio
  import spc7110_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] req,
  input  logic       grant_en,
  output req_id_t    winner,
  output logic       any_req
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            starved;

  assign any_req = |req;
  assign starved = req[REQ_DCU] && (starve_cnt == SC_W'(STARVE_LIMIT));

  always_comb begin
    winner = REQ_SNES;
    if (starved)                winner = REQ_DCU;
    else if (req[REQ_SNES])     winner = REQ_SNES;
    else if (req[REQ_DIRECT])   winner = REQ_DIRECT;
    else if (req[REQ_MCU])      winner = REQ_MCU;
    else if (req[REQ_DCU])      winner = REQ_DCU;
  end

  // Counts grants that bypass a waiting DCU; any DCU idle cycle forgives the debt.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt <= '0;
    end else if (!req[REQ_DCU]) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (winner == REQ_DCU)
        starve_cnt <= '0;
      else if (starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spc7110_psram_arbiter.sv
// SPC7110 PSRAM bus arbiter: four requesters share one PSRAM, each granted
// access runs a fixed OE_n/WE_n window and returns a one-cycle valid/ack.
module spc7110_psram_arbiter
  import spc7110_pkg::*;
#(
  parameter int unsigned ADDR_W        = 23,
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  spc7110_psram_arbiter_if.slave   bus,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(ACCESS_CYCLES - 2);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  req_id_t           owner;
  logic              owner_we;

  logic              snes_pend, direct_pend;
  logic [ADDR_W-1:0] snes_addr_q, direct_addr_q;

  logic [ADDR_W-1:0] psram_addr_q;
  logic [15:0]       psram_dout_q;
  logic              oe_n_q, we_n_q;
  logic [15:0]       snes_data_q, direct_data_q, mcu_rdata_q, dcu_rdata_q;
  logic              snes_valid_q, direct_valid_q, mcu_ack_q, dcu_ack_q;

  logic [3:0]        req_vec;
  req_id_t           winner;
  logic              any_req;
  logic              grant_en;
  logic              last_cycle;

  assign req_vec    = {bus.dcu_req, bus.mcu_req, direct_pend, snes_pend};
  assign grant_en   = (state == ST_IDLE) && any_req;
  assign last_cycle = (state == ST_ACCESS) && (cnt == CNT_LAST);
  assign busy       = (state != ST_IDLE);

  spc7110_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .CLK      (CLK),
    .RESET    (RESET),
    .req      (req_vec),
    .grant_en (grant_en),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (any_req) state_nx = ST_ACCESS;
      ST_ACCESS: if (cnt == CNT_LAST) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Pending flag is consumed at grant rather than at DONE, so a pulse landing
  // during the requester's own access or on its DONE cycle stays queued.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      snes_pend     <= 1'b0;
      direct_pend   <= 1'b0;
      snes_addr_q   <= '0;
      direct_addr_q <= '0;
    end else begin
      if (grant_en && winner == REQ_SNES)   snes_pend   <= 1'b0;
      if (grant_en && winner == REQ_DIRECT) direct_pend <= 1'b0;
      if (bus.snes_req) begin
        snes_pend   <= 1'b1;
        snes_addr_q <= bus.snes_addr;
      end
      if (bus.direct_req) begin
        direct_pend   <= 1'b1;
        direct_addr_q <= bus.direct_addr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt            <= '0;
      owner          <= REQ_SNES;
      owner_we       <= 1'b0;
      psram_addr_q   <= '0;
      psram_dout_q   <= '0;
      oe_n_q         <= 1'b1;
      we_n_q         <= 1'b1;
      snes_data_q    <= '0;
      direct_data_q  <= '0;
      mcu_rdata_q    <= '0;
      dcu_rdata_q    <= '0;
      snes_valid_q   <= 1'b0;
      direct_valid_q <= 1'b0;
      mcu_ack_q      <= 1'b0;
      dcu_ack_q      <= 1'b0;
    end else begin
      snes_valid_q   <= 1'b0;
      direct_valid_q <= 1'b0;
      mcu_ack_q      <= 1'b0;
      dcu_ack_q      <= 1'b0;

      if (grant_en) begin
        cnt      <= '0;
        owner    <= winner;
        owner_we <= (winner == REQ_MCU) && bus.mcu_we;
        case (winner)
          REQ_SNES:   psram_addr_q <= snes_addr_q;
          REQ_DIRECT: psram_addr_q <= direct_addr_q;
          REQ_MCU:    psram_addr_q <= bus.mcu_addr;
          REQ_DCU:    psram_addr_q <= bus.dcu_addr;
          default:    psram_addr_q <= '0;
        endcase
        if (winner == REQ_MCU && bus.mcu_we) begin
          psram_dout_q <= bus.mcu_wdata;
          we_n_q       <= 1'b0;
        end else begin
          oe_n_q <= 1'b0;
        end
      end

      if (state == ST_ACCESS) begin
        cnt <= cnt + 1'b1;
        if (last_cycle) begin
          oe_n_q <= 1'b1;
          we_n_q <= 1'b1;
          case (owner)
            REQ_SNES: begin
              snes_data_q  <= bus.psram_din;
              snes_valid_q <= 1'b1;
            end
            REQ_DIRECT: begin
              direct_data_q  <= bus.psram_din;
              direct_valid_q <= 1'b1;
            end
            REQ_MCU: begin
              if (!owner_we) mcu_rdata_q <= bus.psram_din;
              mcu_ack_q <= 1'b1;
            end
            REQ_DCU: begin
              dcu_rdata_q <= bus.psram_din;
              dcu_ack_q   <= 1'b1;
            end
            default: ;
          endcase
        end else if (owner_we && cnt == CNT_PENULT) begin
          // Release WE_n one cycle early so address and data are held past it.
          we_n_q <= 1'b1;
        end
      end
    end
  end

  assign bus.psram_addr   = psram_addr_q;
  assign bus.psram_dout   = psram_dout_q;
  assign bus.psram_oe_n   = oe_n_q;
  assign bus.psram_we_n   = we_n_q;
  assign bus.snes_data    = snes_data_q;
  assign bus.snes_valid   = snes_valid_q;
  assign bus.direct_data  = direct_data_q;
  assign bus.direct_valid = direct_valid_q;
  assign bus.mcu_rdata    = mcu_rdata_q;
  assign bus.mcu_ack      = mcu_ack_q;
  assign bus.dcu_rdata    = dcu_rdata_q;
  assign bus.dcu_ack      = dcu_ack_q;

endmodule

// File: tb/tb_spc7110_psram_arbiter.sv
// Directed bench for spc7110_psram_arbiter with hand-computed expectations.
module tb_spc7110_psram_arbiter;

  logic CLK;
  logic RESET;
  logic busy;
  int   checks;
  int   errors;

  spc7110_psram_arbiter_if #(.ADDR_W(23)) bus ();

  spc7110_psram_arbiter #(
    .ADDR_W        (23),
    .ACCESS_CYCLES (5),
    .STARVE_LIMIT  (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int bad;
    int sv;
    int we_low;
    int oe_low;
    int acks;
    int vcnt;
    int bcnt;

    checks = 0;
    errors = 0;
    RESET = 1'b1;
    bus.snes_req = 1'b0;   bus.snes_addr = '0;
    bus.direct_req = 1'b0; bus.direct_addr = '0;
    bus.mcu_req = 1'b0;    bus.mcu_we = 1'b0; bus.mcu_addr = '0; bus.mcu_wdata = '0;
    bus.dcu_req = 1'b0;    bus.dcu_addr = '0;
    bus.psram_din = '0;

    // Reset state
    tick(); tick();
    chk("rst_oe_n", bus.psram_oe_n, 1);
    chk("rst_we_n", bus.psram_we_n, 1);
    chk("rst_addr", bus.psram_addr, 0);
    chk("rst_dout", bus.psram_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {bus.snes_valid, bus.direct_valid, bus.mcu_ack, bus.dcu_ack}, 0);
    chk("rst_data", bus.snes_data | bus.direct_data | bus.mcu_rdata | bus.dcu_rdata, 0);
    RESET = 1'b0;
    tick();

    // Single SNES read
    bus.psram_din = 16'hBEEF;
    bus.snes_addr = 23'h000100;
    bus.snes_req = 1'b1;
    tick();
    bus.snes_req = 1'b0;
    chk("s1_idle_oe", bus.psram_oe_n, 1);
    chk("s1_idle_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_oe_low", bus.psram_oe_n, 0);
      chk("s1_addr", bus.psram_addr, 32'h100);
      chk("s1_no_valid", bus.snes_valid, 0);
    end
    tick();
    chk("s1_valid", bus.snes_valid, 1);
    chk("s1_data", bus.snes_data, 32'hBEEF);
    chk("s1_done_oe", bus.psram_oe_n, 1);
    chk("s1_done_busy", busy, 1);
    tick();
    chk("s1_valid_pulse", bus.snes_valid, 0);
    chk("s1_back_idle", busy, 0);

    // Collision: snes first, direct 7 cycles later
    bus.psram_din = 16'h1111;
    bus.snes_addr = 23'h000200;
    bus.direct_addr = 23'h000300;
    bus.snes_req = 1'b1;
    bus.direct_req = 1'b1;
    tick();
    bus.snes_req = 1'b0;
    bus.direct_req = 1'b0;
    n = 1;
    while (!bus.snes_valid && n < 20) begin tick(); n++; end
    chk("c_snes_latency", n, 7);
    chk("c_snes_data", bus.snes_data, 32'h1111);
    chk("c_snes_addr", bus.psram_addr, 32'h200);
    chk("c_direct_not_yet", bus.direct_valid, 0);
    bus.psram_din = 16'h2222;
    n = 0;
    while (!bus.direct_valid && n < 20) begin tick(); n++; end
    chk("c_direct_gap", n, 7);
    chk("c_direct_data", bus.direct_data, 32'h2222);
    chk("c_direct_addr", bus.psram_addr, 32'h300);
    chk("c_snes_data_held", bus.snes_data, 32'h1111);
    tick();

    // No preemption: snes arrives 2 cycles into a DCU access
    bus.psram_din = 16'h5555;
    bus.dcu_addr = 23'h004444;
    bus.dcu_req = 1'b1;
    tick();
    tick();
    bus.snes_addr = 23'h006666;
    bus.snes_req = 1'b1;
    tick();
    bus.snes_req = 1'b0;
    n = 0;
    bad = 0;
    while (!bus.dcu_ack && n < 20) begin
      if (bus.psram_addr !== 23'h004444) bad++;
      tick();
      n++;
    end
    chk("np_dcu_ack", bus.dcu_ack, 1);
    chk("np_addr_stable", bad, 0);
    chk("np_dcu_addr", bus.psram_addr, 32'h4444);
    chk("np_dcu_rdata", bus.dcu_rdata, 32'h5555);
    bus.dcu_req = 1'b0;
    tick();
    chk("np_idle_addr", bus.psram_addr, 32'h4444);
    tick();
    chk("np_snes_addr", bus.psram_addr, 32'h6666);
    chk("np_snes_oe", bus.psram_oe_n, 0);
    n = 0;
    while (!bus.snes_valid && n < 20) begin tick(); n++; end
    chk("np_snes_valid", bus.snes_valid, 1);
    tick();

    // Starvation: DCU forced after the 4th SNES grant
    bus.snes_addr = 23'h0000A0;
    bus.snes_req = 1'b1;
    tick();
    bus.dcu_addr = 23'h000DC0;
    bus.dcu_req = 1'b1;
    n = 0;
    sv = 0;
    while (!bus.dcu_ack && n < 100) begin
      tick();
      n++;
      if (bus.snes_valid) sv++;
    end
    chk("st_dcu_ack", bus.dcu_ack, 1);
    chk("st_snes_grants", sv, 4);
    chk("st_dcu_addr", bus.psram_addr, 32'h0DC0);
    bus.dcu_req = 1'b0;
    bus.snes_req = 1'b0;
    repeat (20) tick();
    chk("st_drained", busy, 0);

    // MCU write at top address
    bus.mcu_addr = 23'h7FFFFF;
    bus.mcu_wdata = 16'h1234;
    bus.mcu_we = 1'b1;
    bus.mcu_req = 1'b1;
    we_low = 0;
    oe_low = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.psram_we_n) we_low++;
      if (!bus.psram_oe_n) oe_low++;
      if (bus.mcu_ack) begin
        acks++;
        chk("w_dout_at_done", bus.psram_dout, 32'h1234);
        chk("w_we_high_at_done", bus.psram_we_n, 1);
        bus.mcu_req = 1'b0;
      end
    end
    bus.mcu_we = 1'b0;
    chk("w_we_low_cycles", we_low, 4);
    chk("w_oe_never_low", oe_low, 0);
    chk("w_ack_count", acks, 1);
    chk("w_addr", bus.psram_addr, 32'h7FFFFF);
    chk("w_dout_held", bus.psram_dout, 32'h1234);

    // Reset in the 3rd ACCESS cycle, with a direct request still pending
    bus.snes_addr = 23'h000011;
    bus.direct_addr = 23'h000055;
    bus.snes_req = 1'b1;
    bus.direct_req = 1'b1;
    tick();
    bus.snes_req = 1'b0;
    bus.direct_req = 1'b0;
    tick(); tick(); tick();
    chk("r_mid_oe", bus.psram_oe_n, 0);
    RESET = 1'b1;
    tick();
    chk("r_oe_n", bus.psram_oe_n, 1);
    chk("r_busy", busy, 0);
    chk("r_addr", bus.psram_addr, 0);
    chk("r_no_valid", bus.snes_valid, 0);
    RESET = 1'b0;
    vcnt = 0;
    bcnt = 0;
    repeat (15) begin
      tick();
      if (bus.snes_valid || bus.direct_valid || bus.mcu_ack || bus.dcu_ack) vcnt++;
      if (busy) bcnt++;
    end
    chk("r_no_valid_after", vcnt, 0);
    chk("r_pend_cleared", bcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
